i2c_cfg_slave: RTL and testbench
================================

// Module: i2c_cfg_slave
// PURPOSE
// - I2C slave register bank; the configuration stage directly upstream of the CIC decimator and FIR filter.
// - Decodes host transactions on sclk/sdata (open-drain, oversampled by clk).
// - Drives the filter control/coefficient signals from a 6-register map.
// PARAMETERS
// - SLV_ADDR  7'h28  7-bit I2C slave address.
// - DECW      2      width of filter_dec_factor, equal to $clog2($clog2(8+1)).
// PORTS
// - clk                input   1     chip clock; must be >= 8x SCL rate.
// - reset_n            input   1     chip reset; asynchronous, active-low.
// - scl_i              input   1     sampled sclk line.
// - sda_i              input   1     sampled sdata line.
// - sda_oe             output  1     1 = pull sdata low; 0 = release (bench glue: sda_drive/sda_val=0).
// - enable             output  1     FIR enable.
// - clear              output  1     CIC clear; 1-clk pulse.
// - filter_dec_factor  output  DECW  CIC decimation select.
// - coef0/coef1/coef2  output  8     FIR taps, signed.
// - div                output  8     FIR output divider, signed.
// BEHAVIOUR
// - Input sync: scl_i/sda_i pass through 2-flop synchronisers; edge detect on the synced values.
// - START = SDA fall while SCL=1; STOP = SDA rise while SCL=1.
// - Data is sampled on SCL rise. sda_oe changes only on SCL fall.
// - Reset values: sda_oe 0, enable 0, clear 0, filter_dec_factor 0, coef0..2 0, div 8'sd1, pointer 0, state IDLE.
// - FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
// - START in any state (including repeated START) -> ADDR; bit counter cleared.
// - STOP in any state -> IDLE; sda_oe=0; a partial byte is discarded.
// - ADDR: shift 8 bits.
//   - Address match -> ADDR_ACK; sda_oe=1 for the 9th clock, released on the following SCL fall.
//   - Mismatch -> IDLE; no ACK.
//   - After ACK: R/W=0 -> REG; R/W=1 -> RDATA.
// - REG: 8 bits load the pointer; ACK; -> WDATA.
// - WDATA: on the SCL fall after the 8th bit:
//   - write reg[pointer]; ACK; pointer+1; -> WDATA.
//   - Outputs update within 4 clk of that fall.
// - Register map:
//   - 0x00 CTRL: bit0 enable; bit1 clear (write 1 -> single clear pulse, reads 0).
//   - 0x01 DEC: [DECW-1:0].
//   - 0x02 COEF0.
//   - 0x03 COEF1.
//   - 0x04 COEF2.
//   - 0x05 DIV.
// - Pointer is 8-bit and wraps 0xFF->0x00.
//   - Writes to 0x06..0xFF: ACKed and ignored.
//   - Reads from 0x06..0xFF: return 0x00.
// - Reserved bits are written as ignored and read back as 0.
// - RDATA: reg[pointer] MSB first; sda_oe = ~bit, changed on SCL fall.
//   - Master ACK (SDA=0 on 9th rise): pointer+1, next byte.
//   - Master NACK: release sda_oe -> IDLE (awaits STOP/START).
// - Simultaneous CTRL write and clear: the clear pulse and enable update occur on the same clk.
// - reset_n low mid-transfer: all outputs return to reset values immediately; bus is released.
// CONFIGURATION
// - I2C_RD_EN defined: read transfers supported as above.
// - I2C_RD_EN undefined:
//   - Address byte with R/W=1 is NACKed -> IDLE.
//   - RDATA/RDATA_ACK logic is not compiled.
// TESTING
// - Reset: reset_n=0 -> enable=0, coef0..2=0, div=1, sda_oe=0.
// - Write 0x28/W, reg 0x02, data 0x7F -> three ACKs; coef0=0x7F; other registers unchanged.
// - Burst: reg 0x02, data 0x05,0xFE,0x03,0x04 -> coef0=5, coef1=-2, coef2=3, div=4; pointer ends at 0x06.
// - Address 0x29/W -> no ACK on 9th clock (sdata stays 1); no register change.
// - CTRL write 0x03 -> enable=1; clear high exactly 1 clk; CTRL readback = 0x01 (I2C_RD_EN).
// - Read (I2C_RD_EN): write ptr 0x05, repeated START, 0x28/R -> 0x04; master ACK, next byte 0x00; NACK+STOP -> IDLE.
//   Without I2C_RD_EN -> address NACK.
// - Abort: STOP after 4 data bits -> no write; reset_n low mid-byte -> outputs reset, sda_oe=0.

Source files
------------

// File: rtl/i2c_cfg_slave.sv
// I2C slave bank of 6 registers driving the CIC/FIR controls; define I2C_RD_EN to enable read transfers.
// Latency: register outputs update about 4 clk after the SCL fall that ends a data byte.
// Backpressure: none. SCL is never stretched, and every byte is ACKed once the slave is addressed.
module i2c_cfg_slave #(
    parameter logic [6:0] SLV_ADDR = 7'h28,
    parameter int         DECW     = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            scl_i,
    input  logic            sda_i,
    output logic            sda_oe,
    output logic            enable,
    output logic            clear,
    output logic [DECW-1:0] filter_dec_factor,
    output logic [7:0]      coef0,
    output logic [7:0]      coef1,
    output logic [7:0]      coef2,
    output logic [7:0]      div
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_REG       = 4'd3;
    localparam logic [3:0] ST_REG_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
`ifdef I2C_RD_EN
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RDATA_ACK = 4'd8;
`endif

    // [0] first sync flop, [1] synchronised value, [2] previous synchronised value
    logic [2:0] scl_sh;
    logic [2:0] sda_sh;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic       addr_ok;

    logic [3:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sh <= 3'b111;
            sda_sh <= 3'b111;
        end else begin
            scl_sh <= {scl_sh[1:0], scl_i};
            sda_sh <= {sda_sh[1:0], sda_i};
        end
    end

    assign scl_rise  =  scl_sh[1] & ~scl_sh[2];
    assign scl_fall  = ~scl_sh[1] &  scl_sh[2];
    assign start_det =  scl_sh[1] &  scl_sh[2] & ~sda_sh[1] &  sda_sh[2];
    assign stop_det  =  scl_sh[1] &  scl_sh[2] &  sda_sh[1] & ~sda_sh[2];

`ifdef I2C_RD_EN
    logic       rw;
    logic [7:0] tx;
    logic [7:0] rd_cur;
    logic [7:0] rd_nxt;

    function automatic logic [7:0] rd_reg(input logic [7:0] a);
        case (a)
            8'h00:   rd_reg = {7'b0, enable};
            8'h01:   rd_reg = {{(8-DECW){1'b0}}, filter_dec_factor};
            8'h02:   rd_reg = coef0;
            8'h03:   rd_reg = coef1;
            8'h04:   rd_reg = coef2;
            8'h05:   rd_reg = div;
            default: rd_reg = 8'h00;
        endcase
    endfunction

    always_comb begin
        rd_cur = rd_reg(ptr);
        rd_nxt = rd_reg(ptr + 8'd1);
    end

    assign addr_ok = (shift[7:1] == SLV_ADDR);
`else
    assign addr_ok = (shift[7:1] == SLV_ADDR) && !shift[0];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ST_IDLE;
            bit_cnt           <= 4'd0;
            shift             <= 8'h00;
            ptr               <= 8'h00;
            sda_oe            <= 1'b0;
            enable            <= 1'b0;
            clear             <= 1'b0;
            filter_dec_factor <= '0;
            coef0             <= 8'h00;
            coef1             <= 8'h00;
            coef2             <= 8'h00;
            div               <= 8'h01;
`ifdef I2C_RD_EN
            rw                <= 1'b0;
            tx                <= 8'h00;
`endif
        end else begin
            clear <= 1'b0;
            if (scl_rise) begin
                shift   <= {shift[6:0], sda_sh[1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state   <= ST_IDLE;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else if (scl_fall) begin
                case (state)
                    ST_ADDR: if (bit_cnt == 4'd8) begin
                        if (addr_ok) begin
                            state  <= ST_ADDR_ACK;
                            sda_oe <= 1'b1;
`ifdef I2C_RD_EN
                            rw     <= shift[0];
`endif
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_ADDR_ACK: begin
                        bit_cnt <= 4'd0;
`ifdef I2C_RD_EN
                        // Put the read MSB on the bus at the same fall that ends the ACK.
                        if (rw) begin
                            state  <= ST_RDATA;
                            sda_oe <= ~rd_cur[7];
                            tx     <= {rd_cur[6:0], 1'b0};
                        end else begin
                            state  <= ST_REG;
                            sda_oe <= 1'b0;
                        end
`else
                        state  <= ST_REG;
                        sda_oe <= 1'b0;
`endif
                    end
                    ST_REG: if (bit_cnt == 4'd8) begin
                        ptr    <= shift;
                        sda_oe <= 1'b1;
                        state  <= ST_REG_ACK;
                    end
                    ST_REG_ACK, ST_WDATA_ACK: begin
                        sda_oe  <= 1'b0;
                        bit_cnt <= 4'd0;
                        state   <= ST_WDATA;
                    end
                    ST_WDATA: if (bit_cnt == 4'd8) begin
                        case (ptr)
                            8'h00: begin
                                enable <= shift[0];
                                clear  <= shift[1];
                            end
                            8'h01:   filter_dec_factor <= shift[DECW-1:0];
                            8'h02:   coef0 <= shift;
                            8'h03:   coef1 <= shift;
                            8'h04:   coef2 <= shift;
                            8'h05:   div   <= shift;
                            default: ;
                        endcase
                        ptr    <= ptr + 8'd1;
                        sda_oe <= 1'b1;
                        state  <= ST_WDATA_ACK;
                    end
`ifdef I2C_RD_EN
                    ST_RDATA: begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe <= 1'b0;
                            state  <= ST_RDATA_ACK;
                        end else begin
                            sda_oe <= ~tx[7];
                            tx     <= {tx[6:0], 1'b0};
                        end
                    end
                    // shift[0] holds the bit the master drove on the 9th rise.
                    ST_RDATA_ACK: begin
                        bit_cnt <= 4'd0;
                        if (!shift[0]) begin
                            ptr    <= ptr + 8'd1;
                            sda_oe <= ~rd_nxt[7];
                            tx     <= {rd_nxt[6:0], 1'b0};
                            state  <= ST_RDATA;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_cfg_slave.sv
// Self-checking bench for i2c_cfg_slave: a bit-banged I2C master, with a scoreboard queue checked by a monitor.
module tb_i2c_cfg_slave;

    localparam int Q = 50;
    localparam int K_REG = 0, K_ACK = 1, K_RD = 2, K_OE = 3, K_CLR = 4, K_CLREN = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, enable, clear;
    logic [1:0] dec;
    logic [7:0] coef0, coef1, coef2, div;

    typedef struct {
        int          kind;
        string       name;
        logic [47:0] exp;
    } exp_t;

    exp_t       exp_q[$];
    event       chk_ev;
    int         n_chk = 0;
    int         n_fail = 0;
    int         clr_cnt = 0;
    int         clren_cnt = 0;
    int         clr_base = 0;
    int         clren_base = 0;
    logic [7:0] rd_byte = 8'h00;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_cfg_slave dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .scl_i             (scl),
        .sda_i             (sda_line),
        .sda_oe            (sda_oe),
        .enable            (enable),
        .clear             (clear),
        .filter_dec_factor (dec),
        .coef0             (coef0),
        .coef1             (coef1),
        .coef2             (coef2),
        .div               (div)
    );

    always @(negedge clk) begin
        if (clear) clr_cnt++;
        if (clear && enable) clren_cnt++;
    end

    // Monitor: pops each expectation and compares it against what the DUT is presenting right now.
    initial forever begin
        @(chk_ev);
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [47:0] act;
            e = exp_q.pop_front();
            case (e.kind)
                K_REG:   act = {7'b0, enable, 6'b0, dec, coef0, coef1, coef2, div};
                K_ACK:   act = {47'b0, ~sda_line};
                K_RD:    act = {40'b0, rd_byte};
                K_OE:    act = {47'b0, sda_oe};
                K_CLR:   act = 48'(clr_cnt - clr_base);
                default: act = 48'(clren_cnt - clren_base);
            endcase
            n_chk++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    function automatic logic [47:0] pk(logic en, logic [1:0] d, logic [7:0] c0,
                                       logic [7:0] c1, logic [7:0] c2, logic [7:0] dv);
        return {7'b0, en, 6'b0, d, c0, c1, c2, dv};
    endfunction

    task automatic chk(int kind, string name, logic [47:0] exp);
        exp_t e;
        e.kind = kind;
        e.name = name;
        e.exp  = exp;
        exp_q.push_back(e);
        -> chk_ev;
        #1;
    endtask

    task automatic i2c_start;
        #Q sda_m = 1'b1;
        #Q scl = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl = 1'b0;
    endtask

    task automatic i2c_stop;
        #Q sda_m = 1'b0;
        #Q scl = 1'b1;
        #Q sda_m = 1'b1;
        #Q;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(logic b);
        #Q sda_m = b;
        #Q scl = 1'b1;
        #(2*Q) scl = 1'b0;
    endtask

    task automatic wr_byte(logic [7:0] b, logic exp_ack, string name);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        #Q sda_m = 1'b1;
        #Q scl = 1'b1;
        #Q chk(K_ACK, name, {47'b0, exp_ack});
        #Q scl = 1'b0;
    endtask

    task automatic rd_byte_t(logic mack, logic [7:0] exp, string name);
        for (int i = 7; i >= 0; i--) begin
            #Q sda_m = 1'b1;
            #Q scl = 1'b1;
            #Q rd_byte[i] = sda_line;
            #Q scl = 1'b0;
        end
        #Q sda_m = ~mack;
        #Q scl = 1'b1;
        #(2*Q) scl = 1'b0;
        chk(K_RD, name, {40'b0, exp});
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (5) @(posedge clk);
        #1;
        chk(K_REG, "reset_regs", pk(1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h01));
        chk(K_OE, "reset_oe", 48'd0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);

        // Single register write
        i2c_start;
        wr_byte(8'h50, 1'b1, "w1_addr_ack");
        wr_byte(8'h02, 1'b1, "w1_reg_ack");
        wr_byte(8'h7F, 1'b1, "w1_dat_ack");
        i2c_stop;
        chk(K_REG, "w1_regs", pk(1'b0, 2'd0, 8'h7F, 8'h00, 8'h00, 8'h01));
        n_chk++;
        if (coef0 !== 8'h7F) begin
            n_fail++;
            $display("FAIL w1_coef0: got %h expected 7f", coef0);
        end

        // Burst write; the extra byte lands on pointer 0x06 and is ignored
        i2c_start;
        wr_byte(8'h50, 1'b1, "b_addr_ack");
        wr_byte(8'h02, 1'b1, "b_reg_ack");
        wr_byte(8'h05, 1'b1, "b_d0_ack");
        wr_byte(8'hFE, 1'b1, "b_d1_ack");
        wr_byte(8'h03, 1'b1, "b_d2_ack");
        wr_byte(8'h04, 1'b1, "b_d3_ack");
        wr_byte(8'h77, 1'b1, "b_ptr6_ack");
        i2c_stop;
        chk(K_REG, "burst_regs", pk(1'b0, 2'd0, 8'h05, 8'hFE, 8'h03, 8'h04));
        n_chk++;
        if (coef1 !== 8'hFE) begin
            n_fail++;
            $display("FAIL burst_coef1: got %h expected fe", coef1);
        end
        n_chk++;
        if (div !== 8'h04) begin
            n_fail++;
            $display("FAIL burst_div: got %h expected 04", div);
        end

        // Wrong address: nothing is ACKed or written
        i2c_start;
        wr_byte(8'h52, 1'b0, "bad_addr_nack");
        wr_byte(8'h02, 1'b0, "bad_reg_nack");
        wr_byte(8'h11, 1'b0, "bad_dat_nack");
        i2c_stop;
        chk(K_REG, "bad_regs", pk(1'b0, 2'd0, 8'h05, 8'hFE, 8'h03, 8'h04));

        // CTRL = 0x03 (enable + one clear pulse), then DEC = 0xFF (reserved bits dropped)
        clr_base   = clr_cnt;
        clren_base = clren_cnt;
        i2c_start;
        wr_byte(8'h50, 1'b1, "c_addr_ack");
        wr_byte(8'h00, 1'b1, "c_reg_ack");
        wr_byte(8'h03, 1'b1, "c_ctrl_ack");
        wr_byte(8'hFF, 1'b1, "c_dec_ack");
        i2c_stop;
        chk(K_REG, "ctrl_regs", pk(1'b1, 2'd3, 8'h05, 8'hFE, 8'h03, 8'h04));
        chk(K_CLR, "clear_pulse_len", 48'd1);
        chk(K_CLREN, "clear_with_enable", 48'd1);
        n_chk++;
        if (enable !== 1'b1) begin
            n_fail++;
            $display("FAIL ctrl_enable: got %b expected 1", enable);
        end

`ifdef I2C_RD_EN
        i2c_start;
        wr_byte(8'h50, 1'b1, "r_addr_ack");
        wr_byte(8'h05, 1'b1, "r_reg_ack");
        i2c_start;
        wr_byte(8'h51, 1'b1, "r_raddr_ack");
        rd_byte_t(1'b1, 8'h04, "rd_div");
        rd_byte_t(1'b0, 8'h00, "rd_reg6");
        rd_byte_t(1'b0, 8'hFF, "rd_after_nack");
        i2c_stop;
        i2c_start;
        wr_byte(8'h50, 1'b1, "r2_addr_ack");
        wr_byte(8'h00, 1'b1, "r2_reg_ack");
        i2c_start;
        wr_byte(8'h51, 1'b1, "r2_raddr_ack");
        rd_byte_t(1'b1, 8'h01, "rd_ctrl");
        rd_byte_t(1'b0, 8'h03, "rd_dec");
        i2c_stop;
`else
        i2c_start;
        wr_byte(8'h50, 1'b1, "r_addr_ack");
        wr_byte(8'h05, 1'b1, "r_reg_ack");
        i2c_start;
        wr_byte(8'h51, 1'b0, "r_raddr_nack");
        i2c_stop;
`endif
        chk(K_REG, "after_read_regs", pk(1'b1, 2'd3, 8'h05, 8'hFE, 8'h03, 8'h04));

        // Pointer wrap 0xFF -> 0x00: second byte clears enable
        i2c_start;
        wr_byte(8'h50, 1'b1, "wr_addr_ack");
        wr_byte(8'hFF, 1'b1, "wr_reg_ack");
        wr_byte(8'h12, 1'b1, "wr_ff_ack");
        wr_byte(8'h00, 1'b1, "wr_00_ack");
        i2c_stop;
        chk(K_REG, "wrap_regs", pk(1'b0, 2'd3, 8'h05, 8'hFE, 8'h03, 8'h04));
        n_chk++;
        if (enable !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_enable: got %b expected 0", enable);
        end

        // STOP after 4 data bits: partial byte discarded
        i2c_start;
        wr_byte(8'h50, 1'b1, "ab_addr_ack");
        wr_byte(8'h03, 1'b1, "ab_reg_ack");
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        i2c_stop;
        chk(K_REG, "abort_regs", pk(1'b0, 2'd3, 8'h05, 8'hFE, 8'h03, 8'h04));

        // Reset mid-byte
        i2c_start;
        wr_byte(8'h50, 1'b1, "rm_addr_ack");
        wr_byte(8'h00, 1'b1, "rm_reg_ack");
        wr_byte(8'h01, 1'b1, "rm_ctrl_ack");
        send_bit(1'b1);
        send_bit(1'b0);
        chk(K_REG, "pre_reset_regs", pk(1'b1, 2'd3, 8'h05, 8'hFE, 8'h03, 8'h04));
        reset_n = 1'b0;
        #1;
        chk(K_REG, "mid_reset_regs", pk(1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h01));
        n_chk++;
        if (div !== 8'h01) begin
            n_fail++;
            $display("FAIL mid_reset_div: got %h expected 01", div);
        end
        n_chk++;
        if (sda_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_oe: got %b expected 0", sda_oe);
        end
        reset_n = 1'b1;
        i2c_stop;

        // Reset while the slave is driving an ACK
        i2c_start;
        for (int i = 7; i >= 0; i--) send_bit(i == 6 || i == 4);
        #Q sda_m = 1'b1;
        #Q chk(K_OE, "ack_driven", 48'd1);
        reset_n = 1'b0;
        #1;
        chk(K_OE, "reset_releases_bus", 48'd0);
        reset_n = 1'b1;
        i2c_stop;

        i2c_start;
        wr_byte(8'h50, 1'b1, "pr_addr_ack");
        wr_byte(8'h02, 1'b1, "pr_reg_ack");
        wr_byte(8'hAA, 1'b1, "pr_dat_ack");
        i2c_stop;
        chk(K_REG, "post_reset_regs", pk(1'b0, 2'd0, 8'hAA, 8'h00, 8'h00, 8'h01));
        n_chk++;
        if (coef0 !== 8'hAA) begin
            n_fail++;
            $display("FAIL post_reset_coef0: got %h expected aa", coef0);
        end

        #100;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
